// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_issuer
// Purpose  : Buffers ALU commands in a small FIFO and issues them one at a
//            time to an external ALU. Each operation waits for the ALU result
//            or a bounded timeout. The result is held on a valid/ready output
//            until consumed, and a new operation is not issued while a result
//            is pending, so results are never overwritten.
// Ports    : CLK, RST            - clock, synchronous active-high reset
//            CMD_VLD/CMD_RDY     - command handshake (CMD_RDY = FIFO not full)
//            CMD_OP/MOVI/REGA/REGB/MEM/IMM - command fields
//            ACT                 - one-cycle ALU operation strobe
//            OP/MOVI/REGA/REGB/MEM/IMM     - registered ALU operands
//            ALU_RDY             - ALU can accept an operation
//            EX_ALU/EX_ALU_VLD   - ALU result and its valid strobe
//            RES_VLD/RES_RDY/RES_DATA      - result handshake
//            ERR_TIMEOUT         - sticky, no ALU response within TIMEOUT
//            ERR_SPURIOUS        - sticky, ALU valid seen outside WAIT
//            OP_CNT              - completed-operation count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VLD,
    output logic                  CMD_RDY,
    input  logic [3:0]            CMD_OP,
    input  logic [1:0]            CMD_MOVI,
    input  logic [DATA_WIDTH-1:0] CMD_REGA,
    input  logic [DATA_WIDTH-1:0] CMD_REGB,
    input  logic [DATA_WIDTH-1:0] CMD_MEM,
    input  logic [DATA_WIDTH-1:0] CMD_IMM,
    output logic                  ACT,
    output logic [3:0]            OP,
    output logic [1:0]            MOVI,
    output logic [DATA_WIDTH-1:0] REGA,
    output logic [DATA_WIDTH-1:0] REGB,
    output logic [DATA_WIDTH-1:0] MEM,
    output logic [DATA_WIDTH-1:0] IMM,
    input  logic                  ALU_RDY,
    input  logic [DATA_WIDTH-1:0] EX_ALU,
    input  logic                  EX_ALU_VLD,
    output logic                  RES_VLD,
    input  logic                  RES_RDY,
    output logic [DATA_WIDTH-1:0] RES_DATA,
    output logic                  ERR_TIMEOUT,
    output logic                  ERR_SPURIOUS,
    output logic [15:0]           OP_CNT
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 6 + 4 * DATA_WIDTH;
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Command FIFO. The entry count is registered, so a command pushed into an
    // empty FIFO only becomes visible to the issue logic on the next cycle.
    // ------------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_ENT_W-1:0] w_entry;
    logic [c_ENT_W-1:0] w_head;
    logic               w_push;
    logic               w_pop;

    logic                  r_act;
    logic [3:0]            r_op;
    logic [1:0]            r_movi;
    logic [DATA_WIDTH-1:0] r_rega;
    logic [DATA_WIDTH-1:0] r_regb;
    logic [DATA_WIDTH-1:0] r_mem_op;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [c_TMO_W-1:0]    r_wait_cnt;
    logic                  r_res_vld;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic                  r_err_timeout;
    logic                  r_err_spurious;
    logic [15:0]           r_op_cnt;

    logic w_capture;
    logic w_timeout;
    logic w_spurious;

    assign CMD_RDY = (r_count != c_FULL) && !RST;
    assign w_push  = CMD_VLD && CMD_RDY;
    assign w_entry = {CMD_OP, CMD_MOVI, CMD_REGA, CMD_REGB, CMD_MEM, CMD_IMM};
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_spurious  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_spurious = EX_ALU_VLD;
                // Blocking on a pending result keeps it from being overwritten.
                if ((r_count != '0) && ALU_RDY && !r_res_vld) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_spurious  = EX_ALU_VLD;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A response on the last allowed cycle still wins over timeout.
                if (EX_ALU_VLD) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_wait_cnt == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Operand, result, error and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_act          <= 1'b0;
            r_op           <= '0;
            r_movi         <= '0;
            r_rega         <= '0;
            r_regb         <= '0;
            r_mem_op       <= '0;
            r_imm          <= '0;
            r_wait_cnt     <= '0;
            r_res_vld      <= 1'b0;
            r_res_data     <= '0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
            r_op_cnt       <= '0;
        end else begin
            // ACT is high for exactly the cycle spent in ISSUE.
            r_act <= w_pop;
            if (w_pop) begin
                {r_op, r_movi, r_rega, r_regb, r_mem_op, r_imm} <= w_head;
            end

            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (w_capture) begin
                r_res_vld  <= 1'b1;
                r_res_data <= EX_ALU;
                r_op_cnt   <= r_op_cnt + 16'd1;
            end else if (r_res_vld && RES_RDY) begin
                r_res_vld <= 1'b0;
            end

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end
            if (w_spurious) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    assign ACT          = r_act;
    assign OP           = r_op;
    assign MOVI         = r_movi;
    assign REGA         = r_rega;
    assign REGB         = r_regb;
    assign MEM          = r_mem_op;
    assign IMM          = r_imm;
    assign RES_VLD      = r_res_vld;
    assign RES_DATA     = r_res_data;
    assign ERR_TIMEOUT  = r_err_timeout;
    assign ERR_SPURIOUS = r_err_spurious;
    assign OP_CNT       = r_op_cnt;

endmodule
`default_nettype wire

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of operands and result.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2): command FIFO entries.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before abort.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port CLK, input, 1 bit: the sole clock, rising-edge.
REQ-006 The block SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port CMD_VLD, input, 1 bit: command offered.
REQ-008 The block SHALL have port CMD_RDY, output, 1 bit: command accepted when CMD_VLD and CMD_RDY are both 1.
REQ-009 The block SHALL have port CMD_OP, input, 4 bits; port CMD_MOVI, input, 2 bits; and ports CMD_REGA, CMD_REGB, CMD_MEM and CMD_IMM, inputs, DATA_WIDTH bits each: command fields.
REQ-010 The block SHALL have port ACT, output, 1 bit: ALU operation strobe.
REQ-011 The block SHALL have port OP, output, 4 bits; port MOVI, output, 2 bits; and ports REGA, REGB, MEM and IMM, outputs, DATA_WIDTH bits each: ALU operands, all registered.
REQ-012 The block SHALL have port ALU_RDY, input, 1 bit: ALU able to accept an operation.
REQ-013 The block SHALL have port EX_ALU, input, DATA_WIDTH bits: ALU result.
REQ-014 The block SHALL have port EX_ALU_VLD, input, 1 bit: EX_ALU valid this cycle.
REQ-015 The block SHALL have port RES_VLD, output, 1 bit; port RES_RDY, input, 1 bit; and port RES_DATA, output, DATA_WIDTH bits: result output handshake.
REQ-016 The block SHALL have port ERR_TIMEOUT, output, 1 bit: sticky, set on WAIT timeout.
REQ-017 The block SHALL have port ERR_SPURIOUS, output, 1 bit: sticky, set on EX_ALU_VLD outside WAIT.
REQ-018 The block SHALL have port OP_CNT, output, 16 bits: completed-operation count, wraps at 0xFFFF to 0.

Function
REQ-019 The block SHALL implement a command FIFO of FIFO_DEPTH entries with CMD_RDY = not full; a push occurs on CMD_VLD and CMD_RDY; the FIFO preserves order.
REQ-020 The block SHALL implement an FSM with states IDLE, ISSUE and WAIT.
REQ-021 IDLE->ISSUE SHALL occur when the FIFO is non-empty, ALU_RDY=1 and RES_VLD=0; the head entry pops and loads OP, MOVI, REGA, REGB, MEM and IMM at that edge.
REQ-022 ACT SHALL be 1 exactly during the single ISSUE cycle and 0 otherwise; ISSUE->WAIT is unconditional.
REQ-023 Operand outputs SHALL hold their values until the next issue.
REQ-024 In WAIT, EX_ALU_VLD=1 SHALL capture EX_ALU into RES_DATA, set RES_VLD, increment OP_CNT, and move to IDLE.
REQ-025 The WAIT cycle counter SHALL start at 0 on entry; if TIMEOUT cycles elapse without EX_ALU_VLD, the block SHALL set ERR_TIMEOUT, discard the operation, leave OP_CNT unchanged, and go to IDLE.
REQ-026 EX_ALU_VLD=1 in IDLE or ISSUE SHALL set ERR_SPURIOUS, with the data ignored.
REQ-027 RES_VLD and RES_DATA SHALL stay stable until RES_RDY=1; the beat clears at that edge.
REQ-028 Issue blocking on RES_VLD SHALL guarantee that a result is never overwritten.
REQ-029 Minimum command-to-result latency SHALL be 3 cycles: push edge, issue edge, ISSUE cycle, then EX_ALU_VLD in the first WAIT cycle, with RES_VLD at the next edge.
REQ-030 A push into an empty FIFO SHALL NOT be issued in the same cycle; head visibility is registered.
REQ-031 Push and pop in the same cycle SHALL both take effect with the entry count unchanged.

Reset
REQ-032 While RST=1 at a clock edge, the block SHALL empty the FIFO and set the FSM to IDLE.
REQ-033 While RST=1 at a clock edge, ACT, RES_VLD, ERR_TIMEOUT and ERR_SPURIOUS SHALL be 0; OP_CNT SHALL be 0; and OP, MOVI, REGA, REGB, MEM, IMM and RES_DATA SHALL be 0.
REQ-034 Reset mid-operation in ISSUE or WAIT SHALL abandon the in-flight operation with no result produced and no error flag set.
REQ-035 CMD_RDY SHALL be 0 while RST=1 and 1 in the first cycle after reset.

Verification
REQ-036 Basic: push OP=0x1, REGA=0x05, REGB=0x03; the ALU returns EX_ALU=0x08 one cycle after ACT -> ACT pulses once with REGA=0x05, RES_DATA=0x08 with RES_VLD, OP_CNT=1.
REQ-037 Backpressure: with ALU_RDY=0, push 5 commands -> CMD_RDY drops after 4 and no ACT occurs; then raise ALU_RDY -> 4 results leave in push order.
REQ-038 Result stall: hold RES_RDY=0 with 2 commands queued -> one ACT only, RES_VLD held and RES_DATA stable; release RES_RDY -> the second ACT follows.
REQ-039 Timeout: with TIMEOUT=16, never assert EX_ALU_VLD -> ERR_TIMEOUT=1 after 16 WAIT cycles, no RES_VLD, OP_CNT unchanged, and the next command issues normally.
REQ-040 Spurious and reset: EX_ALU_VLD in IDLE -> ERR_SPURIOUS=1; RST asserted in WAIT -> all outputs at reset values and no result emitted.
REQ-041 Wrap: preload OP_CNT=0xFFFF by 65535 operations or force, then complete one more -> OP_CNT=0x0000.
